psum_drain_quant: RTL and testbench

Drain-side stage directly downstream of the partial-sum buffer. Once a kernel's accumulation completes, it reads a range of spatial addresses from the buffer. For each of the ARRAY_DIM lanes it adds a per-channel bias, applies a rounding arithmetic right shift, applies optional ReLU, and saturates to signed OUT_WIDTH. Each packed pixel is then streamed to the output/writeback stage over a valid/ready handshake.

---
 rtl/psum_drain_quant.sv | 206 ++++++++++++++++++++
 tb/tb_psum_drain_quant.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain_quant.sv
// Drain stage behind the partial-sum buffer. It reads a range of pixels, then per lane
// adds bias, applies a rounding shift, optional ReLU and saturation, and streams each pixel out.
module psum_drain_quant #(
    parameter int ARRAY_DIM   = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [ADDR_WIDTH:0]            num_pixels,
    input  logic [SHIFT_WIDTH-1:0]         shift,
    input  logic                           relu_en,
    input  logic [ARRAY_DIM*ACC_WIDTH-1:0] bias,
    output logic                           busy,
    output logic                           done,
    output logic                           buf_rd_en,
    output logic [ADDR_WIDTH-1:0]          buf_addr,
    input  logic [ARRAY_DIM*ACC_WIDTH-1:0] buf_rdata,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ARRAY_DIM*OUT_WIDTH-1:0] out_data,
    output logic                           out_last,
    output logic [1:0]                     o_dbg_state
);
    // Handshake: a pixel transfers on a cycle with out_valid=1 and out_ready=1; while
    // out_valid=1 and out_ready=0, out_data/out_last stay stable and out_valid stays high.

    localparam int SW = ACC_WIDTH + 2;
    localparam int PW = ARRAY_DIM * OUT_WIDTH;
    localparam logic signed [SW-1:0] QMAX = SW'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [SW-1:0] QMIN = SW'(-(2 ** (OUT_WIDTH - 1)));

    typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

    state_t                         r_state;
    logic                           r_busy;
    logic                           r_done;
    logic [ADDR_WIDTH-1:0]          r_addr;
    logic [ADDR_WIDTH:0]            r_issued;
    logic [ADDR_WIDTH:0]            r_num;
    logic [SHIFT_WIDTH-1:0]         r_shift;
    logic                           r_relu;
    logic [ARRAY_DIM*ACC_WIDTH-1:0] r_bias;
    logic                           r_rvalid;
    logic                           r_rlast;

    logic                           r_head_valid;
    logic [PW-1:0]                  r_head_data;
    logic                           r_head_last;
    logic                           r_tail_valid;
    logic [PW-1:0]                  r_tail_data;
    logic                           r_tail_last;

    logic                           w_pop;
    logic                           w_push;
    logic [1:0]                     w_occ;
    logic                           w_rd_en;
    logic [ADDR_WIDTH:0]            w_issued_nxt;
    logic                           w_last_issue;
    logic                           w_drained;
    logic [PW-1:0]                  w_qdata;

    function automatic logic [OUT_WIDTH-1:0] quant(
        input logic [ACC_WIDTH-1:0]   psum,
        input logic [ACC_WIDTH-1:0]   b,
        input logic [SHIFT_WIDTH-1:0] sh,
        input logic                   relu
    );
        logic signed [SW-1:0] s;
        logic signed [SW-1:0] rnd;
        logic signed [SW-1:0] r;
        s   = $signed({{2{psum[ACC_WIDTH-1]}}, psum}) + $signed({{2{b[ACC_WIDTH-1]}}, b});
        rnd = '0;
        if (sh != '0) rnd = SW'(1) << (sh - SHIFT_WIDTH'(1));
        r = (s + rnd) >>> sh;
        if (relu && (r < 0)) r = '0;
        if (r > QMAX) r = QMAX;
        if (r < QMIN) r = QMIN;
        return r[OUT_WIDTH-1:0];
    endfunction

    always_comb begin
        w_qdata = '0;
        for (int i = 0; i < ARRAY_DIM; i++) begin
            w_qdata[i*OUT_WIDTH +: OUT_WIDTH] = quant(buf_rdata[i*ACC_WIDTH +: ACC_WIDTH],
                                                      r_bias[i*ACC_WIDTH +: ACC_WIDTH],
                                                      r_shift, r_relu);
        end
    end

    // A read issued now lands in the FIFO at the end of the next cycle, so only
    // entries already buffered or returning this cycle compete for the two slots.
    assign w_pop        = r_head_valid && out_ready;
    assign w_push       = r_rvalid;
    assign w_occ        = {1'b0, r_head_valid} + {1'b0, r_tail_valid} + {1'b0, r_rvalid} - {1'b0, w_pop};
    assign w_rd_en      = (r_state == S_READ) && (w_occ < 2'd2);
    assign w_issued_nxt = r_issued + (ADDR_WIDTH + 1)'(1);
    assign w_last_issue = (w_issued_nxt == r_num);
    assign w_drained    = !r_rvalid && !r_tail_valid && (!r_head_valid || w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_addr   <= '0;
            r_issued <= '0;
            r_num    <= '0;
            r_shift  <= '0;
            r_relu   <= 1'b0;
            r_bias   <= '0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_rvalid <= w_rd_en;
            r_rlast  <= w_rd_en && w_last_issue;
            if (w_rd_en) begin
                r_addr   <= r_addr + ADDR_WIDTH'(1);
                r_issued <= w_issued_nxt;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr   <= base_addr;
                        r_issued <= '0;
                        r_num    <= num_pixels;
                        r_shift  <= shift;
                        r_relu   <= relu_en;
                        r_bias   <= bias;
                        if (num_pixels == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_READ;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (w_rd_en && w_last_issue) r_state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (w_drained) r_state <= S_DONE;
                end
                S_DONE: begin
                    // done is registered, so it rises as busy falls, one cycle after DONE.
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
            r_head_last  <= 1'b0;
            r_tail_valid <= 1'b0;
            r_tail_data  <= '0;
            r_tail_last  <= 1'b0;
        end else if (!r_head_valid) begin
            if (w_push) begin
                r_head_valid <= 1'b1;
                r_head_data  <= w_qdata;
                r_head_last  <= r_rlast;
            end
        end else if (w_pop) begin
            if (r_tail_valid) begin
                r_head_data <= r_tail_data;
                r_head_last <= r_tail_last;
                if (w_push) begin
                    r_tail_data <= w_qdata;
                    r_tail_last <= r_rlast;
                end else begin
                    r_tail_valid <= 1'b0;
                end
            end else if (w_push) begin
                r_head_data <= w_qdata;
                r_head_last <= r_rlast;
            end else begin
                r_head_valid <= 1'b0;
            end
        end else if (w_push) begin
            r_tail_valid <= 1'b1;
            r_tail_data  <= w_qdata;
            r_tail_last  <= r_rlast;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign buf_rd_en   = w_rd_en;
    assign buf_addr    = r_addr;
    assign out_valid   = r_head_valid;
    assign out_data    = r_head_data;
    assign out_last    = r_head_last;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_psum_drain_quant.sv
// Bench for psum_drain_quant: buffer memory model, ready patterns, and a scoreboard
// of expected pixels and read addresses filled when each drain is started.
module tb_psum_drain_quant;
    localparam int AD  = 16;
    localparam int AW  = 32;
    localparam int OW  = 8;
    localparam int ADW = 10;
    localparam int SHW = 5;
    localparam int PW  = AD * OW;
    localparam int DW  = AD * AW;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [ADW-1:0] base_addr;
    logic [ADW:0]   num_pixels;
    logic [SHW-1:0] shift;
    logic           relu_en;
    logic [DW-1:0]  bias;
    logic           busy;
    logic           done;
    logic           buf_rd_en;
    logic [ADW-1:0] buf_addr;
    logic [DW-1:0]  buf_rdata;
    logic           out_valid;
    logic           out_ready;
    logic [PW-1:0]  out_data;
    logic           out_last;
    logic [1:0]     o_dbg_state;

    psum_drain_quant #(
        .ARRAY_DIM(AD), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .ADDR_WIDTH(ADW), .SHIFT_WIDTH(SHW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_pixels(num_pixels), .shift(shift), .relu_en(relu_en), .bias(bias),
        .busy(busy), .done(done), .buf_rd_en(buf_rd_en), .buf_addr(buf_addr),
        .buf_rdata(buf_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // buffer model: data valid one cycle after the read request
    logic [DW-1:0] mem [1024];
    always @(posedge clk) if (buf_rd_en) buf_rdata <= mem[buf_addr];

    // ready driver
    int ready_mode = 0;
    int pat_idx = 0;
    bit pat [6];
    always @(posedge clk) begin
        #1;
        pat_idx++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = pat[pat_idx % 6];
            2:       out_ready = ($urandom_range(0, 1) == 1);
            default: out_ready = 1'b0;
        endcase
    end

    // reference quantiser
    function automatic logic [OW-1:0] q_model(longint p, longint b, int sh, bit relu);
        longint s, r, d;
        s = p + b;
        if (sh == 0) begin
            r = s;
        end else begin
            d = longint'(1) << sh;
            r = s + d / 2;
            if (r >= 0) r = r / d;
            else        r = -((-r + d - 1) / d);
        end
        if (relu && r < 0) r = 0;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r[OW-1:0];
    endfunction

    // scoreboard
    logic [PW:0]    exp_q[$];
    logic [ADW-1:0] addr_q[$];
    logic [PW:0]    mon_e;
    logic           stall_prev = 1'b0;
    logic [PW-1:0]  held_data;
    logic           held_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 128'(out_valid), 128'(1));
                chk("stall_data", out_data, held_data);
                chk("stall_last", 128'(out_last), 128'(held_last));
            end
            if (buf_rd_en) begin
                if (addr_q.size() == 0) chk("extra_read", 128'(buf_addr), 128'(1024));
                else chk("rd_addr", 128'(buf_addr), 128'(addr_q.pop_front()));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", out_data, ~out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", out_data, mon_e[PW-1:0]);
                    chk("beat_last", 128'(out_last), 128'(mon_e[PW]));
                end
            end
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
        end
    end

    // driver tasks
    function automatic logic [DW-1:0] rand_bias();
        logic [DW-1:0] v;
        for (int i = 0; i < AD; i++) v[i*AW +: AW] = int'($urandom_range(0, 4000)) - 2000;
        return v;
    endfunction

    task automatic start_drain(input int base, input int n, input int sh, input bit relu,
                               input logic [DW-1:0] b);
        int             a;
        logic [PW-1:0]  px;
        logic signed [AW-1:0] pv, bv;
        @(posedge clk); #1;
        base_addr  = ADW'(base);
        num_pixels = (ADW + 1)'(n);
        shift      = SHW'(sh);
        relu_en    = relu;
        bias       = b;
        start      = 1'b1;
        for (int k = 0; k < n; k++) begin
            a = (base + k) % 1024;
            addr_q.push_back(ADW'(a));
            for (int i = 0; i < AD; i++) begin
                pv = mem[a][i*AW +: AW];
                bv = b[i*AW +: AW];
                px[i*OW +: OW] = q_model(longint'(pv), longint'(bv), sh, relu);
            end
            exp_q.push_back({(k == n - 1), px});
        end
        @(posedge clk); #1;
        start      = 1'b0;
        base_addr  = ADW'($urandom);
        num_pixels = (ADW + 1)'($urandom);
        shift      = SHW'($urandom);
        relu_en    = ~relu;
        bias       = rand_bias();
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 128'(seen), 128'(1));
        chk({tag, "_busy_low"}, 128'(busy), 128'(0));
        chk({tag, "_drained"}, 128'(exp_q.size()), 128'(0));
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 128'(done), 128'(0));
    endtask

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [DW-1:0] b0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        b0 = '0;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_pixels = '0; shift = '0;
        relu_en = 1'b0; bias = '0; out_ready = 1'b1; buf_rdata = '0;
        for (int a = 0; a < 1024; a++)
            for (int i = 0; i < AD; i++) mem[a][i*AW +: AW] = int'($urandom) >>> $urandom_range(0, 30);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_rd_en", 128'(buf_rd_en), 128'(0));
        chk("rst_addr", 128'(buf_addr), 128'(0));
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_data", out_data, 128'(0));
        chk("rst_last", 128'(out_last), 128'(0));
        chk("rst_state", 128'(o_dbg_state), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // basic: lanes = 100*addr, all saturate
        for (int a = 5; a < 9; a++)
            for (int i = 0; i < AD; i++) mem[a][i*AW +: AW] = 100 * a;
        start_drain(5, 4, 0, 1'b0, b0);
        @(negedge clk);
        chk("lat_rd_en", 128'(buf_rd_en), 128'(1));
        chk("lat_busy", 128'(busy), 128'(1));
        chk("lat_valid_c1", 128'(out_valid), 128'(0));
        @(negedge clk);
        chk("lat_valid_c2", 128'(out_valid), 128'(0));
        @(negedge clk);
        chk("lat_valid_c3", 128'(out_valid), 128'(1));
        chk("basic_sat", out_data, {PW/8{8'h7f}});
        wait_done("basic");

        // rounding: +300,-300,+5,-5 with bias 4, shift 3
        for (int i = 0; i < AD; i++) begin
            case (i % 4)
                0: mem[100][i*AW +: AW] = 300;
                1: mem[100][i*AW +: AW] = -300;
                2: mem[100][i*AW +: AW] = 5;
                default: mem[100][i*AW +: AW] = -5;
            endcase
            b0[i*AW +: AW] = 4;
        end
        start_drain(100, 1, 3, 1'b0, b0);
        wait_done("round");
        b0 = '0;
        for (int i = 0; i < AD; i++) mem[200][i*AW +: AW] = (i % 2 == 0) ? 2000 : -2000;
        start_drain(200, 1, 0, 1'b0, b0);
        wait_done("sat");

        // relu on/off
        for (int i = 0; i < AD; i++) mem[300][i*AW +: AW] = -40;
        start_drain(300, 1, 1, 1'b1, b0);
        wait_done("relu_on");
        start_drain(300, 1, 1, 1'b0, b0);
        wait_done("relu_off");

        // backpressure
        ready_mode = 1;
        start_drain(400, 8, 4, 1'b0, rand_bias());
        wait_done("bp");
        ready_mode = 0;

        // address wrap
        start_drain(1022, 4, 2, 1'b0, rand_bias());
        wait_done("wrap");

        // zero pixels: done two cycles after start, no beats
        start_drain(50, 0, 0, 1'b0, b0);
        @(negedge clk);
        chk("zero_done_c1", 128'(done), 128'(0));
        chk("zero_busy_c1", 128'(busy), 128'(0));
        @(negedge clk);
        chk("zero_done_c2", 128'(done), 128'(1));
        @(negedge clk);
        chk("zero_done_c3", 128'(done), 128'(0));

        // start while busy is ignored
        ready_mode = 1;
        start_drain(500, 6, 5, 1'b1, rand_bias());
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'd900; num_pixels = 11'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_start");

        // random drains under random backpressure
        ready_mode = 2;
        repeat (3) begin
            start_drain(int'($urandom_range(0, 1023)), int'($urandom_range(1, 12)),
                        int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), rand_bias());
            wait_done("rand");
        end

        // reset mid-drain with two pixels buffered
        ready_mode = 3;
        start_drain(600, 6, 3, 1'b0, rand_bias());
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_valid", 128'(out_valid), 128'(1));
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_state", 128'(o_dbg_state), 128'(0));
        chk("mid_rst_rd_en", 128'(buf_rd_en), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_mode = 0;
        start_drain(700, 5, 6, 1'b0, rand_bias());
        wait_done("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
